// File: rtl/c2h_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | c2h_pkg : shared widths, beat geometry and FSM states for the C2H serializer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package c2h_pkg;

  localparam int IN_W       = 4072;
  localparam int BEAT_W     = 512;
  localparam int KEEP_W     = BEAT_W / 8;
  localparam int NBEATS     = (IN_W + BEAT_W - 1) / BEAT_W;
  localparam int LAST_BYTES = (IN_W - (NBEATS - 1) * BEAT_W) / 8;
  localparam int BUF_W      = NBEATS * BEAT_W;
  localparam int IDX_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  // Low LAST_BYTES lanes enabled on the final beat of a record.
  localparam logic [KEEP_W-1:0] LAST_KEEP = {KEEP_W{1'b1}} >> (KEEP_W - LAST_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    NEXT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/c2h_beat_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | c2h_beat_serializer : splits one packed record into AXIS beats for XDMA C2H |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module c2h_beat_serializer
  import c2h_pkg::*;
(
  input  logic              m_axis_c2h_aclk,
  input  logic              m_axis_c2h_areset,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              data_next,
  output logic [BEAT_W-1:0] m_axis_c2h_tdata,
  output logic [KEEP_W-1:0] m_axis_c2h_tkeep,
  output logic              m_axis_c2h_tvalid,
  output logic              m_axis_c2h_tlast,
  input  logic              m_axis_c2h_tready,
  output logic              busy,
  output logic              overrun,
  output logic [31:0]       rec_cnt
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BUF_W-1:0]   r_buf;
  logic [IDX_W-1:0]   r_beat_idx;
  logic               r_overrun;
  logic [31:0]        r_rec_cnt;
  logic               w_accept;
  logic               w_last_beat;

  assign w_last_beat = (r_beat_idx == IDX_W'(NBEATS - 1));
  assign w_accept    = (r_state == SEND) && m_axis_c2h_tready;

  always_comb begin
    w_state_nxt       = r_state;
    m_axis_c2h_tvalid = 1'b0;
    m_axis_c2h_tkeep  = '0;
    m_axis_c2h_tlast  = 1'b0;
    data_next         = 1'b0;
    busy              = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_nxt = SEND;
      end
      SEND: begin
        m_axis_c2h_tvalid = 1'b1;
        m_axis_c2h_tlast  = w_last_beat;
        m_axis_c2h_tkeep  = w_last_beat ? LAST_KEEP : {KEEP_W{1'b1}};
        busy              = 1'b1;
        if (w_accept && w_last_beat) w_state_nxt = NEXT;
      end
      NEXT: begin
        data_next   = 1'b1;
        busy        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // tdata is a direct tap of the buffer, so it stays stable while the sink stalls.
  assign m_axis_c2h_tdata = r_buf[BEAT_W-1:0];
  assign overrun          = r_overrun;
  assign rec_cnt          = r_rec_cnt;

  always_ff @(posedge m_axis_c2h_aclk) begin
    if (m_axis_c2h_areset) begin
      r_state    <= IDLE;
      r_buf      <= '0;
      r_beat_idx <= '0;
      r_overrun  <= 1'b0;
      r_rec_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && in_valid) begin
        r_buf      <= BUF_W'(in_data);
        r_beat_idx <= '0;
      end else if (w_accept) begin
        r_buf      <= r_buf >> BEAT_W;
        r_beat_idx <= r_beat_idx + IDX_W'(1);
      end
      // Upstream must wait for data_next; a pulse while busy is dropped and flagged.
      if (in_valid && (r_state != IDLE)) r_overrun <= 1'b1;
      if (w_accept && w_last_beat) r_rec_cnt <= r_rec_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: doc/c2h_beat_serializer.md
Name: c2h_beat_serializer

Overview:
- Downstream stage of the 4072-bit record packer; consumes one packed record per valid pulse and serializes it into 512-bit AXI4-Stream beats for the XDMA C2H channel.
- Returns a one-cycle data_next pulse to the packer once the last beat of the record has been accepted, so the packer can advance its record counter.
- Tracks completed records and flags protocol overruns from upstream.

Parameters:
- IN_W, 4072, width of the packed record (data_num in bits [7:0]).
- BEAT_W, 512, AXIS tdata width; must be a multiple of 8.
- NBEATS, ceil(IN_W/BEAT_W) = 8, beats per record (derived, not overridable).
- LAST_BYTES, (IN_W - (NBEATS-1)*BEAT_W)/8 = 61, valid bytes in the final beat (derived).

Ports:
- m_axis_c2h_aclk  in  1  sole clock.
- m_axis_c2h_areset  in  1  reset; synchronous, active-high.
- in_data  in  IN_W  packed record from the packer.
- in_valid  in  1  one-cycle pulse; in_data is valid in that cycle.
- data_next  out  1  one-cycle pulse: record fully sent, upstream may advance.
- m_axis_c2h_tdata  out  BEAT_W  beat payload.
- m_axis_c2h_tkeep  out  BEAT_W/8  byte enables.
- m_axis_c2h_tvalid  out  1  beat valid.
- m_axis_c2h_tlast  out  1  final beat of the record.
- m_axis_c2h_tready  in  1  sink ready.
- busy  out  1  high in SEND and NEXT.
- overrun  out  1  sticky: in_valid arrived while not IDLE.
- rec_cnt  out  32  records completed; wraps at 2^32.

Behaviour:
- Reset (sampled on clock edge while m_axis_c2h_areset=1):
  - State goes to IDLE.
  - All outputs go to 0: tdata, tkeep, tvalid, tlast, data_next, busy, overrun, rec_cnt.
  - Reset mid-record abandons the record immediately; no partial tlast is issued.
- Shift buffer:
  - Width is NBEATS*BEAT_W = 4096 bits.
  - Loaded as {24'b0, in_data}.
  - tdata is always the low BEAT_W bits of the buffer.
  - The buffer shifts right by BEAT_W on every accepted beat.
- Beat index: 3-bit counter beat_idx.
- FSM, IDLE:
  - tvalid=0.
  - When in_valid=1: capture in_data, beat_idx<=0, go to SEND.
  - tvalid rises in the next cycle (latency 1).
- FSM, SEND:
  - tvalid=1.
  - tkeep is all ones, except when beat_idx=NBEATS-1: then the low LAST_BYTES bits are 1 (0x1FFF_FFFF_FFFF_FFFF) and the rest 0.
  - tlast = (beat_idx==NBEATS-1).
  - A beat is accepted when tvalid & tready. On acceptance: shift the buffer and increment beat_idx.
  - If the accepted beat has tlast=1: go to NEXT and increment rec_cnt.
  - While tready=0, tdata/tkeep/tlast/tvalid are held stable (AXIS rule).
  - With tready held high, a record takes exactly NBEATS consecutive cycles.
- FSM, NEXT:
  - data_next=1 for exactly one cycle, tvalid=0, then IDLE.
- Timing: data_next asserts in the cycle after the tlast handshake.
- Overrun:
  - in_valid in SEND or NEXT sets overrun=1 (sticky until reset).
  - The offending data is ignored and the current record is unaffected.
- in_valid in the same cycle as the IDLE entry from NEXT (i.e. during NEXT) counts as overrun.
- Back-to-back records:
  - The earliest acceptable in_valid is the first IDLE cycle after NEXT.
  - Minimum record period is NBEATS+2 cycles.
- rec_cnt wraps from 0xFFFF_FFFF to 0 with no flag.

Decomposition:
- Shared package c2h_pkg holds:
  - IN_W, BEAT_W, NBEATS, LAST_BYTES.
  - The FSM state enum {IDLE, SEND, NEXT}.
  - The LAST_KEEP constant.
- No sub-module; the buffer, FSM and counters stay in one module.

Test Plan:
- Reset hold: assert m_axis_c2h_areset for 3 cycles with in_valid=1 -> all outputs 0, no tvalid after release.
- Single record, tready=1: in_data = bytes 0..508 incrementing, data_num=8'h05 -> 8 beats on consecutive cycles starting 1 cycle after in_valid. Required response:
  - beat0 tdata[7:0]=8'h05.
  - tkeep=all ones on beats 0-6; beat7 tkeep=64'h1FFF_FFFF_FFFF_FFFF with tlast=1.
  - data_next one cycle later; rec_cnt=1.
- Backpressure: tready toggles 1,0,0,1 repeating -> tdata/tkeep/tlast stable during stalls, 8 handshakes total, data_next exactly once.
- Overrun: second in_valid pulse at beat 3 of a record -> overrun=1 from the next cycle, current record completes unchanged, second record never sent, rec_cnt=1.
- Reset mid-record: reset after beat 4 handshake -> tvalid=0, rec_cnt=0 next cycle; a fresh record afterwards sends beats 0-7 correctly.
- Back-to-back: in_valid pulses spaced NBEATS+2 cycles, 3 records -> rec_cnt=3, no overrun, 3 data_next pulses.
